// File: rtl/lsu.sv
// lsu: load/store unit and data-bus master between EX and the data memory bus.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_*                     EX request: valid, read, write, funct3, byte address, store data
//   lsu_flush                 squashes the request presented this cycle (IDLE only)
//   lsu_readdata              formatted load result, held until the next load completes
//   lsu_stall                 pipeline hold while a transaction is starting or outstanding
//   exc_*_addr_misaligned     combinational misalignment flags
//   bus_*                     word-aligned, byte-enabled bus with waitrequest/readdatavalid
module lsu #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_read,
    input  logic          req_write,
    input  logic [2:0]    req_opcode,
    input  logic [AW-1:0] req_address,
    input  logic [DW-1:0] req_writedata,
    input  logic          lsu_flush,
    output logic [DW-1:0] lsu_readdata,
    output logic          lsu_stall,
    output logic          exc_load_addr_misaligned,
    output logic          exc_store_addr_misaligned,
    output logic          bus_read,
    output logic          bus_write,
    output logic [AW-1:0] bus_address,
    output logic [3:0]    bus_byteenable,
    output logic [DW-1:0] bus_writedata,
    input  logic          bus_waitrequest,
    input  logic          bus_readdatavalid,
    input  logic [DW-1:0] bus_readdata
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state;
    logic done, mis, start;
    logic [2:0] f3;
    logic [1:0] off;
    logic [3:0] be;
    logic [DW-1:0] wd, s, fmt;
    // funct3[1] set means word size (covers 010, 011 and 11x); otherwise [0] picks half over byte
    assign mis = req_opcode[1] ? |req_address[1:0] : req_opcode[0] & req_address[0];
    assign exc_load_addr_misaligned = req_valid & req_read & mis;
    assign exc_store_addr_misaligned = req_valid & req_write & mis;
    // done blocks re-issue of the still-presented request in the release cycle
    assign start = req_valid & (req_read | req_write) & ~mis & ~lsu_flush & ~done & (state == IDLE);
    assign lsu_stall = ~rst & (start | (state != IDLE));
    assign be = req_opcode[1] ? 4'b1111 : (req_opcode[0] ? 4'b0011 : 4'b0001) << req_address[1:0];
    assign wd = req_opcode[1] ? req_writedata : req_opcode[0] ? {2{req_writedata[15:0]}} : {4{req_writedata[7:0]}};
    assign s = bus_readdata >> {off, 3'b000};
    assign fmt = f3[1] ? s : f3[0] ? {{16{~f3[2] & s[15]}}, s[15:0]} : {{24{~f3[2] & s[7]}}, s[7:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done <= 1'b0;
            bus_read <= 1'b0;
            bus_write <= 1'b0;
            bus_address <= '0;
            bus_byteenable <= '0;
            bus_writedata <= '0;
            lsu_readdata <= '0;
            f3 <= '0;
            off <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= BUS;
                    // read wins when both read and write are set
                    bus_read <= req_read;
                    bus_write <= ~req_read;
                    bus_address <= {req_address[AW-1:2], 2'b00};
                    bus_byteenable <= be;
                    bus_writedata <= wd;
                    f3 <= req_opcode;
                    off <= req_address[1:0];
                end
                BUS: if (!bus_waitrequest) begin
                    bus_read <= 1'b0;
                    bus_write <= 1'b0;
                    state <= bus_write ? IDLE : RESP;
                    done <= bus_write;
                end
                RESP: if (bus_readdatavalid) begin
                    lsu_readdata <= fmt;
                    state <= IDLE;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
